viterbi_deframer: RTL and testbench

VITERBI_DEFRAMER -- requirements
Module: viterbi_deframer

---
 rtl/viterbi_deframer_pkg.sv | 17 +
 rtl/vd_byte_fifo.sv | 78 +++++++
 rtl/viterbi_deframer.sv | 192 +++++++++++++++++++
 tb/tb_viterbi_deframer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_deframer_pkg.sv
// rtl/viterbi_deframer_pkg.sv - shared constants and types for the Viterbi output deframer
//
// Holds the default frame sync pattern, the framer state encodings, the
// byte FIFO depth and the width of a FIFO entry ({sof, eof, data[7:0]}).
package viterbi_deframer_pkg;

    localparam logic [15:0] VD_SYNC_WORD_DEF = 16'hEB90;
    localparam int          VD_FIFO_DEPTH    = 4;
    localparam int          VD_TAG_W         = 10;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        VERIFY  = 2'd2
    } vd_state_e;

endpackage

// File: rtl/vd_byte_fifo.sv
// rtl/vd_byte_fifo.sv - 4-entry tagged byte FIFO with registered head outputs
//
// Ports:
//   CLOCK     in   clock
//   Reset     in   synchronous active-low reset
//   wr_en     in   write strobe for wr_data
//   wr_data   in   {sof, eof, data[7:0]}
//   rd_ready  in   consumer accept; pop when rd_valid && rd_ready
//   rd_data   out  head entry, zero while empty
//   rd_valid  out  head entry present
//   overflow  out  sticky: a write was dropped because the FIFO was full
//
// The head registers are loaded from the post-pop state, before this edge's
// write lands, so a freshly written entry appears one edge after the write.
// rd_valid therefore never runs ahead of the stored count.
module vd_byte_fifo
    import viterbi_deframer_pkg::*;
(
    input  logic                CLOCK,
    input  logic                Reset,
    input  logic                wr_en,
    input  logic [VD_TAG_W-1:0] wr_data,
    input  logic                rd_ready,
    output logic [VD_TAG_W-1:0] rd_data,
    output logic                rd_valid,
    output logic                overflow
);

    localparam int AW = $clog2(VD_FIFO_DEPTH);

    logic [VD_TAG_W-1:0] mem [VD_FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       rd_ptr_pop;
    logic [AW:0]         count;
    logic [AW:0]         count_pop;
    logic                pop;
    logic                full;
    logic                accept;

    always_comb begin
        pop        = rd_valid && rd_ready;
        full       = (count == (AW+1)'(VD_FIFO_DEPTH));
        // a pop in the same cycle frees the slot the write needs
        accept     = wr_en && (!full || pop);
        rd_ptr_pop = rd_ptr + AW'(pop);
        count_pop  = count - (AW+1)'(pop);
    end

    always_ff @(posedge CLOCK) begin
        if (accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr   <= rd_ptr_pop;
            count    <= count_pop + (AW+1)'(accept);
            if (wr_en && full && !pop) begin
                overflow <= 1'b1;
            end
            rd_valid <= (count_pop != '0);
            rd_data  <= (count_pop != '0) ? mem[rd_ptr_pop] : '0;
        end
    end

endmodule

// File: rtl/viterbi_deframer.sv
// rtl/viterbi_deframer.sv - sync-word framer and byte packer for decoded Viterbi bits
//
// Ports:
//   CLOCK       in   single clock
//   Reset       in   synchronous active-low reset
//   Active      in   decoder running; low returns the framer to HUNT
//   bit_valid   in   one-cycle strobe per decoded bit
//   bit_in      in   decoded bit, sampled when bit_valid=1
//   byte_data   out  payload byte at FIFO head
//   byte_valid  out  FIFO non-empty
//   byte_ready  in   consumer accept
//   sof         out  head byte is first of its frame
//   eof         out  head byte is last of its frame
//   locked      out  framer in PAYLOAD or VERIFY
//   overflow    out  sticky byte-drop flag
//
// Build option: define VD_SYNC_INV_EN to also lock on the inverted sync
// word; payload and following sync checks are then taken as inverted.
module viterbi_deframer
    import viterbi_deframer_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD     = VD_SYNC_WORD_DEF,
    parameter int          PAYLOAD_BYTES = 16,
    parameter int          MAX_MISS      = 2
)(
    input  logic       CLOCK,
    input  logic       Reset,
    input  logic       Active,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       sof,
    output logic       eof,
    output logic       locked,
    output logic       overflow
);

    localparam logic [10:0] LAST_PBIT = 11'(8*PAYLOAD_BYTES - 1);
    localparam logic [2:0]  MISS_LIM  = 3'(MAX_MISS);

    vd_state_e           state;
    logic [15:0]         shreg;
    logic [4:0]          fill;       // bits seen in HUNT, saturates at 16
    logic [10:0]         bit_cnt;    // payload bit index, or verify bit index
    logic [2:0]          miss_cnt;
    logic [6:0]          pack;
    logic                wr_en;
    logic [VD_TAG_W-1:0] wr_data;
    logic [VD_TAG_W-1:0] fifo_head;

    logic                bv;
    logic [15:0]         shift_nxt;
    logic [15:0]         sync_exp;
    logic                hit_true;
    logic                hit;
    logic                pbit;
    logic                pay_en;
`ifdef VD_SYNC_INV_EN
    logic                inv_q;
    logic                hit_inv;
    logic                inv_now;
`endif

    always_comb begin
        bv        = bit_valid && Active;
        shift_nxt = {shreg[14:0], bit_in};
        // fill guard keeps a cleared register from matching an all-zero sync
        hit_true  = (fill == 5'd16) && (shreg == SYNC_WORD);
`ifdef VD_SYNC_INV_EN
        hit_inv   = (fill == 5'd16) && (shreg == ~SYNC_WORD) && !hit_true;
        inv_now   = (state == HUNT) ? hit_inv : inv_q;
        hit       = hit_true || hit_inv;
        pbit      = bit_in ^ inv_now;
        sync_exp  = inv_q ? ~SYNC_WORD : SYNC_WORD;
`else
        hit       = hit_true;
        pbit      = bit_in;
        sync_exp  = SYNC_WORD;
`endif
        // A bit arriving on the edge that leaves HUNT is the first payload bit.
        pay_en    = bv && ((state == PAYLOAD) || ((state == HUNT) && hit));
    end

    always_ff @(posedge CLOCK) begin
        if (!Reset) begin
            state    <= HUNT;
            locked   <= 1'b0;
            shreg    <= '0;
            fill     <= '0;
            bit_cnt  <= '0;
            miss_cnt <= '0;
            pack     <= '0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
`ifdef VD_SYNC_INV_EN
            inv_q    <= 1'b0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (pay_en) begin
                pack <= {pack[5:0], pbit};
                if (bit_cnt[2:0] == 3'd7) begin
                    wr_en   <= 1'b1;
                    wr_data <= {(bit_cnt[10:3] == 8'd0), (bit_cnt == LAST_PBIT), pack, pbit};
                end
            end

            if (!Active) begin
                state    <= HUNT;
                locked   <= 1'b0;
                shreg    <= '0;
                fill     <= '0;
                bit_cnt  <= '0;
                miss_cnt <= '0;
                pack     <= '0;
            end else begin
                case (state)
                    HUNT: begin
                        if (hit) begin
                            state    <= PAYLOAD;
                            locked   <= 1'b1;
                            miss_cnt <= '0;
                            bit_cnt  <= bv ? 11'd1 : 11'd0;
`ifdef VD_SYNC_INV_EN
                            inv_q    <= hit_inv;
`endif
                        end else if (bv) begin
                            shreg <= shift_nxt;
                            if (fill != 5'd16) begin
                                fill <= fill + 5'd1;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (bv) begin
                            if (bit_cnt == LAST_PBIT) begin
                                state   <= VERIFY;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 11'd1;
                            end
                        end
                    end
                    VERIFY: begin
                        if (bv) begin
                            shreg <= shift_nxt;
                            if (bit_cnt == 11'd15) begin
                                bit_cnt <= '0;
                                if (shift_nxt == sync_exp) begin
                                    miss_cnt <= '0;
                                    state    <= PAYLOAD;
                                end else if ((miss_cnt + 3'd1) == MISS_LIM) begin
                                    state    <= HUNT;
                                    locked   <= 1'b0;
                                    shreg    <= '0;
                                    fill     <= '0;
                                    miss_cnt <= '0;
                                end else begin
                                    // flywheel: assume the frame is still aligned
                                    miss_cnt <= miss_cnt + 3'd1;
                                    state    <= PAYLOAD;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 11'd1;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    vd_byte_fifo u_fifo (
        .CLOCK    (CLOCK),
        .Reset    (Reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_ready (byte_ready),
        .rd_data  (fifo_head),
        .rd_valid (byte_valid),
        .overflow (overflow)
    );

    assign {sof, eof, byte_data} = fifo_head;

endmodule

// File: tb/tb_viterbi_deframer.sv
// tb/tb_viterbi_deframer.sv - randomized self-checking bench for viterbi_deframer
module tb_viterbi_deframer;

    localparam logic [15:0] SW = 16'hEB90;
    localparam int NB = 16;
    localparam int MM = 2;
    localparam int M_HUNT = 0;
    localparam int M_PAY  = 1;
    localparam int M_VER  = 2;

    logic       CLOCK = 1'b0;
    logic       Reset = 1'b0;
    logic       Active = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       sof;
    logic       eof;
    logic       locked;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;

    logic [9:0] expq [$];

    int          m_mode;
    logic [15:0] m_win;
    int          m_fill;
    int          m_cnt;
    int          m_miss;
    logic        m_inv;
    logic [7:0]  m_byte;

    viterbi_deframer dut (
        .CLOCK      (CLOCK),
        .Reset      (Reset),
        .Active     (Active),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .sof        (sof),
        .eof        (eof),
        .locked     (locked),
        .overflow   (overflow)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_clear();
        m_mode = M_HUNT;
        m_win  = '0;
        m_fill = 0;
        m_cnt  = 0;
        m_miss = 0;
        m_inv  = 1'b0;
    endtask

    // Reference framer: consumes the accepted bit stream one bit at a time.
    task automatic m_bit(input logic b);
        logic [15:0] want;
        if (m_mode == M_HUNT) begin
            m_win = {m_win[14:0], b};
            if (m_fill < 16) m_fill++;
            if (m_fill == 16 && m_win == SW) begin
                m_mode = M_PAY; m_cnt = 0; m_miss = 0; m_inv = 1'b0;
            end
`ifdef VD_SYNC_INV_EN
            else if (m_fill == 16 && m_win == ~SW) begin
                m_mode = M_PAY; m_cnt = 0; m_miss = 0; m_inv = 1'b1;
            end
`endif
        end else if (m_mode == M_PAY) begin
            m_byte = {m_byte[6:0], b ^ m_inv};
            m_cnt++;
            if (m_cnt % 8 == 0) expq.push_back({(m_cnt == 8), (m_cnt == 8*NB), m_byte});
            if (m_cnt == 8*NB) begin
                m_mode = M_VER; m_cnt = 0;
            end
        end else begin
            m_win = {m_win[14:0], b};
            m_cnt++;
            if (m_cnt == 16) begin
                want  = m_inv ? ~SW : SW;
                m_cnt = 0;
                if (m_win == want) begin
                    m_miss = 0; m_mode = M_PAY;
                end else begin
                    m_miss++;
                    if (m_miss >= MM) begin
                        m_mode = M_HUNT; m_win = '0; m_fill = 0; m_miss = 0;
                    end else begin
                        m_mode = M_PAY;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
        case (ready_mode)
            0:       byte_ready = 1'b1;
            1:       byte_ready = (($urandom % 4) != 0);
            default: byte_ready = 1'b0;
        endcase
    endtask

    task automatic send_bit(input logic b, input int gap);
        for (int i = 0; i < gap; i++) tick();
        if (gap > 0) check("locked_track", 32'(locked), 32'(m_mode != M_HUNT));
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        if (Active) m_bit(b);
    endtask

    task automatic send_word(input logic [15:0] w, input int gmax);
        for (int i = 15; i >= 0; i--) send_bit(w[i], $urandom_range(0, gmax));
    endtask

    task automatic send_byte(input logic [7:0] v, input int gmax);
        for (int i = 7; i >= 0; i--) send_bit(v[i], $urandom_range(0, gmax));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || byte_valid) && n < 200) begin
            tick();
            n++;
        end
        check("drain_queue", 32'(expq.size()), 32'd0);
        check("drain_valid", 32'(byte_valid), 32'd0);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        expq.delete();
        m_clear();
    endtask

    // Scoreboard: every accepted head byte must match the reference order.
    always @(negedge CLOCK) begin
        if (Reset && byte_valid && byte_ready) begin
            if (expq.size() == 0) check("pop_unexpected", 32'({sof, eof, byte_data}), 32'h400);
            else check("pop_byte", 32'({sof, eof, byte_data}), 32'(expq.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] w;
        m_clear();
        m_byte = '0;

        // reset values
        tick(); tick();
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_sof", 32'(sof), 32'd0);
        check("rst_eof", 32'(eof), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_byte_data", 32'(byte_data), 32'd0);
        Reset = 1'b1;
        Active = 1'b1;
        ready_mode = 0;
        tick();

        // clean frame with first-byte latency check
        send_word(SW, 1);
        for (int i = 7; i >= 0; i--) send_bit(1'b0, (i == 7) ? 1 : 0);
        check("lat_s0", 32'(byte_valid), 32'd0);
        tick();
        check("lat_s1", 32'(byte_valid), 32'd0);
        tick();
        check("lat_s2", 32'(byte_valid), 32'd1);
        check("lat_data", 32'(byte_data), 32'h00);
        check("lat_sof", 32'(sof), 32'd1);
        for (int k = 1; k < NB; k++) send_byte(8'(k), 2);
        for (int i = 15; i >= 0; i--) begin
            send_bit(SW[i], $urandom_range(0, 1));
            check("sync2_locked", 32'(locked), 32'd1);
        end
        drain();

        // two corrupted syncs: first flywheeled, second drops lock
        for (int k = 0; k < NB; k++) send_byte(8'($urandom), 1);
        send_word(16'hEB91, 1);
        check("fly_locked", 32'(locked), 32'd1);
        for (int k = 0; k < NB; k++) send_byte(8'($urandom), 1);
        for (int i = 15; i >= 0; i--) send_bit(w_bit(16'hEB91, i), 0);
        check("lock_lost", 32'(locked), 32'd0);
        drain();

        // randomized frame stream with occasional corrupted syncs
        ready_mode = 1;
        for (int j = 0; j < $urandom_range(0, 20); j++) send_bit(1'($urandom), $urandom_range(0, 2));
        for (int f = 0; f < 10; f++) begin
            w = SW;
            if ($urandom % 4 == 0) w = SW ^ (16'h1 << $urandom_range(0, 15));
            send_word(w, 2);
            for (int k = 0; k < NB; k++) send_byte(8'($urandom), 2);
        end
        ready_mode = 0;
        drain();
        check("rand_overflow", 32'(overflow), 32'd0);

        // overflow: six bytes into a stalled four-entry FIFO
        Active = 1'b0; tick(); Active = 1'b1; m_clear();
        ready_mode = 2; tick();
        send_word(SW, 1);
        for (int k = 0; k < 6; k++) send_byte(8'(k), 1);
        repeat (3) tick();
        check("ovf_valid", 32'(byte_valid), 32'd1);
        check("ovf_head", 32'({sof, eof, byte_data}), 32'h200);
        check("ovf_flag", 32'(overflow), 32'd1);
        tick();
        check("ovf_hold", 32'({sof, eof, byte_data}), 32'h200);
        void'(expq.pop_back());
        void'(expq.pop_back());
        ready_mode = 0;
        drain();

        // reset after payload byte 3
        do_reset();
        check("rst2_overflow", 32'(overflow), 32'd0);
        ready_mode = 2;
        send_word(SW, 1);
        for (int k = 0; k < 3; k++) send_byte(8'(8'hA0 + k), 1);
        repeat (3) tick();
        check("pre_rst_valid", 32'(byte_valid), 32'd1);
        do_reset();
        check("mid_rst_valid", 32'(byte_valid), 32'd0);
        check("mid_rst_locked", 32'(locked), 32'd0);
        check("mid_rst_data", 32'({sof, eof, byte_data}), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        ready_mode = 0;
        for (int k = 0; k < 5; k++) send_byte(8'h00, 1);
        repeat (3) tick();
        check("post_rst_quiet", 32'(byte_valid), 32'd0);
        send_word(SW, 1);
        for (int k = 0; k < NB; k++) send_byte(8'($urandom), 1);
        drain();

        // Active drop mid-payload keeps already written bytes
        send_word(SW, 1);
        ready_mode = 2;
        send_byte(8'h3C, 1);
        send_byte(8'hC3, 1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1);
        Active = 1'b0;
        tick();
        m_clear();
        check("act_locked", 32'(locked), 32'd0);
        check("act_valid", 32'(byte_valid), 32'd1);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom), 1);
        ready_mode = 0;
        drain();
        check("act_locked_after", 32'(locked), 32'd0);
        Active = 1'b1;
        tick();

`ifdef VD_SYNC_INV_EN
        // inverted sync then A5 yields 5A
        ready_mode = 2;
        send_word(16'h146F, 1);
        send_byte(8'hA5, 1);
        repeat (3) tick();
        check("inv_byte", 32'(byte_data), 32'h5A);
        check("inv_sof", 32'(sof), 32'd1);
        check("inv_locked", 32'(locked), 32'd1);
        ready_mode = 0;
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic w_bit(input logic [15:0] w, input int i);
        return w[i];
    endfunction

endmodule
